// File: rtl/repeat_sub_divider.sv
// Repeated-subtraction divider for 4-bit unsigned operands.
// The subtractor itself lives outside this block: sub1/sub2 are driven from
// the remainder/divisor registers and sub/cout_sub come back combinationally.
//
//   state | meaning
//   IDLE  | waiting for start; ready=1
//   RUN   | one trial subtraction per cycle until a borrow appears
//   DONE  | one-cycle completion pulse; results already registered
module repeat_sub_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       ready,
  output logic [3:0] sub1,
  output logic [3:0] sub2,
  input  logic [3:0] sub,
  input  logic       cout_sub,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       done,
  output logic       div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] rem_reg;
  logic [3:0] dvs_reg;
  logic [3:0] q_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = (divisor == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cout_sub) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  // The quotient cannot wrap: with a 4-bit dividend the largest count is
  // 15 (15/1), and the remainder reaches 0 before q_reg would overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg   <= 4'd0;
      dvs_reg   <= 4'd0;
      q_reg     <= 4'd0;
      quotient  <= 4'd0;
      remainder <= 4'd0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem_reg  <= dividend;
            dvs_reg  <= divisor;
            q_reg    <= 4'd0;
            div_zero <= 1'b0;
            if (divisor == 4'd0) begin
              quotient  <= 4'hF;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!cout_sub) begin
            rem_reg <= sub;
            q_reg   <= q_reg + 4'd1;
          end else begin
            quotient  <= q_reg;
            remainder <= rem_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sub1 = rem_reg;
  assign sub2 = dvs_reg;

endmodule

// File: doc/repeat_sub_divider.md
REPEAT_SUB_DIVIDER -- requirements
Module: repeat_sub_divider

Interface
REQ-001: clk  input  1  rising-edge clock for all state.
REQ-002: rst_n  input  1  asynchronous, active-low reset.
REQ-003: start  input  1  request a division; sampled only while ready=1.
REQ-004: dividend  input  4  unsigned dividend; captured on the accepted start edge.
REQ-005: divisor  input  4  unsigned divisor; captured on the accepted start edge.
REQ-006: ready  output  1  high only in IDLE.
REQ-007: sub1  output  4  minuend to the 4-bit full subtractor; equals the internal remainder register.
REQ-008: sub2  output  4  subtrahend to the full subtractor; equals the internal divisor register.
REQ-009: sub  input  4  subtractor difference, (sub1 - sub2) mod 16, combinational from sub1/sub2.
REQ-010: cout_sub  input  1  subtractor borrow; 1 iff sub1 < sub2 (unsigned).
REQ-011: quotient  output  4  registered quotient of the last completed operation.
REQ-012: remainder  output  4  registered remainder of the last completed operation.
REQ-013: done  output  1  one-cycle completion pulse.
REQ-014: div_zero  output  1  registered flag: last completed operation had divisor 0.

Function
REQ-015: The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016: In IDLE with start=1 at a rising edge: rem_reg<=dividend, dvs_reg<=divisor, q_reg<=0, div_zero<=0; next state RUN if divisor!=0, else DONE.
REQ-017: start SHALL be ignored in RUN and DONE; operands presented then have no effect.
REQ-018: In RUN with cout_sub=0: rem_reg<=sub, q_reg<=q_reg+1, stay in RUN.
REQ-019: In RUN with cout_sub=1: rem_reg and q_reg hold; quotient<=q_reg, remainder<=rem_reg; next state DONE.
REQ-020: Divide-by-zero path, on the IDLE->DONE edge: quotient<=4'hF, remainder<=dividend, div_zero<=1.
REQ-021: In DONE, done=1 for exactly that one cycle; next state IDLE unconditionally.
REQ-022: Latency: the start-sampling edge is edge 1; for a true quotient q, subtractions occur on edges 2..q+1, and DONE is entered on edge q+2 (edge 1 for divisor 0).
REQ-023: q_reg SHALL NOT wrap: maximum quotient is 15 (15/1), reached before any borrow.
REQ-024: quotient, remainder and div_zero SHALL hold their values from DONE until the next completion; div_zero clears only on an accepted start.
REQ-025: sub1/sub2 SHALL be driven from the registers in all states; sub and cout_sub are consumed only in RUN.
REQ-026: ready SHALL be decoded from state (combinational), with no dependency on start.

Reset
REQ-027: On rst_n=0, asynchronously: state=IDLE; rem_reg, dvs_reg, q_reg, quotient, remainder=0; done=0; div_zero=0; hence ready=1, sub1=0, sub2=0.
REQ-028: Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; the first accepted start after release SHALL be processed normally.

Verification
REQ-029: dividend=13, divisor=4, start for 1 cycle -> done on the cycle after edge 5; quotient=3, remainder=1, div_zero=0.
REQ-030: 15/1 -> done after edge 17; quotient=15, remainder=0; no quotient wrap.
REQ-031: 3/5 -> done after edge 2; quotient=0, remainder=3.
REQ-032: 9/0 -> done after edge 1; quotient=4'hF, remainder=9, div_zero=1; next start 8/8 -> quotient=1, remainder=0, div_zero=0.
REQ-033: start with 14/2, then start held high with 1/1 during RUN -> second request ignored; result quotient=7, remainder=0; ready=0 until IDLE.
REQ-034: rst_n pulsed low mid-RUN of 12/3 -> all outputs 0 immediately and no done pulse; a subsequent 12/3 returns quotient=4, remainder=0.
